// File: rtl/uart_cmd_decoder.sv
// Turns 4-byte uart frames (column, row, char, EOL) into single-cycle screen buffer writes.
// Define CMD_CLEAR_EN to make byte 8'hFF in the column slot start a full-screen clear sweep.
module uart_cmd_decoder #(
  parameter int         N_COL          = 160,
  parameter int         N_ROW          = 60,
  parameter int         N_COL_WIDTH    = 8,
  parameter int         N_ROW_WIDTH    = 6,
  parameter int         N_CHARS_WIDTH  = 7,
  parameter logic [7:0] EOL_CHAR       = 8'h0A,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         TIMEOUT_WIDTH  = 20
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_i,
  input  logic [7:0]               data_i,
  output logic                     wr_en_o,
  output logic [N_COL_WIDTH-1:0]   col_w_o,
  output logic [N_ROW_WIDTH-1:0]   row_w_o,
  output logic [N_CHARS_WIDTH-1:0] din_o,
  output logic                     err_o,
  output logic                     busy_o
);

  // state   | meaning
  // S_COL   | idle, next accepted byte is the column
  // S_ROW   | column captured, waiting for row byte
  // S_CHAR  | row captured, char byte triggers the write (or error)
  // S_EOL   | waiting for the end-of-line byte
  // S_CLEAR | clear sweep writing blanks to every cell
  typedef enum logic [2:0] {S_COL, S_ROW, S_CHAR, S_EOL, S_CLEAR} state_t;

  state_t                   state_q, state_d;
  logic                     wr_q, accept, timeout;
  logic                     bad_q, bad_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic [N_COL_WIDTH-1:0]   col_q, col_d, col_w_d;
  logic [N_ROW_WIDTH-1:0]   row_q, row_d, row_w_d;
  logic [N_CHARS_WIDTH-1:0] din_d;
  logic                     wr_en_d, err_d;
  logic [7:0]               col_fold;

`ifdef CMD_CLEAR_EN
  logic busy_q, busy_d;
  assign busy_o = busy_q;
`else
  assign busy_o = 1'b0;
`endif

  assign accept   = wr_i & ~wr_q;
  // a single subtraction suffices: 255 - N_COL is already below N_COL
  assign col_fold = (data_i >= 8'(N_COL)) ? data_i - 8'(N_COL) : data_i;
  assign timeout  = (cnt_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    col_d   = col_q;
    row_d   = row_q;
    col_w_d = col_w_o;
    row_w_d = row_w_o;
    din_d   = din_o;
    wr_en_d = 1'b0;
    err_d   = 1'b0;
`ifdef CMD_CLEAR_EN
    busy_d  = 1'b0;
`endif

    // an accept in the timeout cycle takes priority over the resync
    if ((state_q == S_ROW || state_q == S_CHAR || state_q == S_EOL) && !accept) begin
      if (timeout) begin
        state_d = S_COL;
        bad_d   = 1'b0;
        err_d   = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
      end
    end

    case (state_q)
      S_COL: begin
        cnt_d = '0;
        if (accept) begin
`ifdef CMD_CLEAR_EN
          if (data_i == 8'hFF) begin
            state_d = S_CLEAR;
            busy_d  = 1'b1;
            wr_en_d = 1'b1;
            col_w_d = '0;
            row_w_d = '0;
            din_d   = N_CHARS_WIDTH'(8'h20);
          end else
`endif
          begin
            col_d   = N_COL_WIDTH'(col_fold);
            bad_d   = 1'b0;
            state_d = S_ROW;
          end
        end
      end
      S_ROW: begin
        if (accept) begin
          row_d   = data_i[N_ROW_WIDTH-1:0];
          bad_d   = bad_q | (data_i >= 8'(N_ROW));
          cnt_d   = '0;
          state_d = S_CHAR;
        end
      end
      S_CHAR: begin
        if (accept) begin
          if (data_i[7] || bad_q) begin
            err_d = 1'b1;
          end else begin
            wr_en_d = 1'b1;
            col_w_d = col_q;
            row_w_d = row_q;
            din_d   = data_i[N_CHARS_WIDTH-1:0];
          end
          cnt_d   = '0;
          state_d = S_EOL;
        end
      end
      S_EOL: begin
        if (accept) begin
          err_d   = (data_i != EOL_CHAR);
          bad_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_COL;
        end
      end
`ifdef CMD_CLEAR_EN
      S_CLEAR: begin
        err_d = accept;
        // the output cell registers double as the sweep cursor
        if (col_w_o == N_COL_WIDTH'(N_COL - 1) && row_w_o == N_ROW_WIDTH'(N_ROW - 1)) begin
          state_d = S_COL;
        end else begin
          busy_d  = 1'b1;
          wr_en_d = 1'b1;
          din_d   = N_CHARS_WIDTH'(8'h20);
          if (col_w_o == N_COL_WIDTH'(N_COL - 1)) begin
            col_w_d = '0;
            row_w_d = row_w_o + N_ROW_WIDTH'(1);
          end else begin
            col_w_d = col_w_o + N_COL_WIDTH'(1);
          end
        end
      end
`endif
      default: state_d = S_COL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_COL;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      col_w_o <= '0;
      row_w_o <= '0;
      din_o   <= '0;
      wr_en_o <= 1'b0;
      err_o   <= 1'b0;
`ifdef CMD_CLEAR_EN
      busy_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wr_q    <= wr_i;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      col_q   <= col_d;
      row_q   <= row_d;
      col_w_o <= col_w_d;
      row_w_o <= row_w_d;
      din_o   <= din_d;
      wr_en_o <= wr_en_d;
      err_o   <= err_d;
`ifdef CMD_CLEAR_EN
      busy_q  <= busy_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: directed frames plus random byte streams against a frame-level model.
// Define CMD_CLEAR_EN to also exercise the clear sweep.
module tb_uart_cmd_decoder;

  localparam int N_COL = 160;
  localparam int N_ROW = 60;
  localparam int TMO   = 100;

  logic       clk_i  = 1'b0;
  logic       rst_i  = 1'b1;
  logic       wr_i   = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       wr_en_o, err_o, busy_o;
  logic [7:0] col_w_o;
  logic [5:0] row_w_o;
  logic [6:0] din_o;

  uart_cmd_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_i    (wr_i),
    .data_i  (data_i),
    .wr_en_o (wr_en_o),
    .col_w_o (col_w_o),
    .row_w_o (row_w_o),
    .din_o   (din_o),
    .err_o   (err_o),
    .busy_o  (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc      = 0;
  int n_tests  = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;
  int busy_cnt = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // expected events keyed by the clock edge after which they are visible
  bit exp_wr[int];
  bit exp_err[int];
  bit exp_busy[int];
  int exp_col[int];
  int exp_row[int];
  int exp_din[int];

  // frame-level reference state
  int pos       = 0;
  int m_col     = 0;
  int m_row     = 0;
  bit m_bad     = 1'b0;
  int tmo_at    = -1;
  int sweep_end = -1;
  int last_e    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_byte(input int b, input int e);
    if (tmo_at >= 0) begin
      if (e <= tmo_at) begin
        exp_err.delete(tmo_at);
      end else begin
        pos   = 0;
        m_bad = 1'b0;
      end
      tmo_at = -1;
    end
`ifdef CMD_CLEAR_EN
    if (sweep_end >= 0 && e <= sweep_end) begin
      exp_err[e] = 1'b1;
      return;
    end
    if (pos == 0 && b == 255) begin
      for (int k = 0; k < N_COL * N_ROW; k++) begin
        exp_wr[e + k]   = 1'b1;
        exp_busy[e + k] = 1'b1;
        exp_col[e + k]  = k % N_COL;
        exp_row[e + k]  = k / N_COL;
        exp_din[e + k]  = 32;
      end
      sweep_end = e + N_COL * N_ROW;
      return;
    end
`endif
    case (pos)
      0: begin
        m_col = (b >= N_COL) ? b - N_COL : b;
        m_bad = 1'b0;
      end
      1: begin
        m_row = b % 64;
        m_bad = (b >= N_ROW);
      end
      2: begin
        if (b >= 128 || m_bad) begin
          exp_err[e] = 1'b1;
        end else begin
          exp_wr[e]  = 1'b1;
          exp_col[e] = m_col;
          exp_row[e] = m_row;
          exp_din[e] = b;
        end
      end
      default: begin
        if (b != 10) exp_err[e] = 1'b1;
        m_bad = 1'b0;
      end
    endcase
    pos = (pos + 1) % 4;
    if (pos != 0) begin
      tmo_at = e + TMO;
      exp_err[tmo_at] = 1'b1;
    end
  endfunction

  function automatic void model_reset();
    if (tmo_at > cyc) exp_err.delete(tmo_at);
    tmo_at = -1;
    pos    = 0;
    m_bad  = 1'b0;
  endfunction

  always @(posedge clk_i) begin
    #1;
    if (mon_en) begin
      chk("wr_en", wr_en_o, exp_wr.exists(cyc));
      chk("err", err_o, exp_err.exists(cyc));
      chk("busy", busy_o, exp_busy.exists(cyc));
      if (busy_o) busy_cnt++;
      if (exp_wr.exists(cyc)) begin
        chk("col", col_w_o, exp_col[cyc]);
        chk("row", row_w_o, exp_row[cyc]);
        chk("din", din_o, exp_din[cyc]);
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // assumes wr_i was low during the previous cycle
  task automatic send_byte(input int b, input int hold, input int gap);
    data_i = 8'(b);
    wr_i   = 1'b1;
    last_e = cyc + 1;
    model_byte(b, last_e);
    step(1);
    data_i = 8'($urandom);
    step(hold - 1);
    wr_i = 1'b0;
    step(gap);
  endtask

  task automatic send_frame(input int b0, input int b1, input int b2, input int b3);
    send_byte(b0, 1, $urandom_range(1, 2));
    send_byte(b1, 1, $urandom_range(1, 2));
    send_byte(b2, 1, $urandom_range(1, 2));
    send_byte(b3, 1, $urandom_range(1, 2));
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    model_reset();
    step(2);
    chk("rst_col", col_w_o, 0);
    chk("rst_row", row_w_o, 0);
    chk("rst_din", din_o, 0);
    rst_i = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    step(3);
    chk("rst_wr_en", wr_en_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_col", col_w_o, 0);
    chk("rst_row", row_w_o, 0);
    chk("rst_din", din_o, 0);
    rst_i  = 1'b0;
    mon_en = 1'b1;
    step(2);

    send_frame(8'h05, 8'h03, 8'h41, 8'h0A);
    send_frame(8'hA5, 8'h00, 8'h5A, 8'h0A);
    send_frame(8'h01, 8'd60, 8'h41, 8'h0A);
    send_frame(8'h06, 8'h07, 8'h48, 8'h0A);
    send_frame(8'h9F, 8'h3B, 8'h7F, 8'h0A);
    send_frame(8'hA0, 8'h3F, 8'h30, 8'h0A);
    send_frame(8'h10, 8'h11, 8'h80, 8'h0A);

    // inter-byte timeout: err exactly TMO edges after the last accept
    send_byte(8'h01, 1, 1);
    send_byte(8'h02, 1, 1);
    seen = -1;
    for (int i = 0; i < TMO + 10 && seen < 0; i++) begin
      if (err_o) seen = cyc;
      else step(1);
    end
    chk("tmo_latency", seen - last_e, TMO);
    step(2);
    send_frame(8'h0B, 8'h0C, 8'h4D, 8'h0A);

    // accept landing in the timeout cycle wins
    send_byte(8'h03, 1, 1);
    send_byte(8'h04, 1, 1);
    step(last_e + TMO - 1 - cyc);
    send_byte(8'h43, 1, 1);
    send_byte(8'h0A, 1, 2);

    // one cycle later the timeout fires first and the byte starts a new frame
    send_byte(8'h09, 1, 1);
    send_byte(8'h09, 1, 1);
    step(last_e + TMO - cyc);
    send_frame(8'h44, 8'h02, 8'h45, 8'h0A);

    send_frame(8'h02, 8'h04, 8'h46, 8'h0D);

    // reset mid-frame discards the partial frame
    send_byte(8'h01, 1, 1);
    send_byte(8'h02, 1, 1);
    do_reset();
    step(1);
    send_byte(8'h41, 1, 1);
    send_byte(8'h0A, 1, 1);
    send_byte(8'h50, 1, 1);
    send_byte(8'h0A, 1, 2);

`ifndef CMD_CLEAR_EN
    send_frame(8'hFF, 8'h01, 8'h30, 8'h0A);
`endif

    for (int i = 0; i < 400; i++) begin
      int b;
      int gap;
      case (pos)
        0: begin
          b = $urandom_range(0, 255);
`ifdef CMD_CLEAR_EN
          if (b == 255) b = 254;
`endif
        end
        1: b = ($urandom_range(0, 99) < 80) ? $urandom_range(0, N_ROW - 1) : $urandom_range(N_ROW, 255);
        2: b = ($urandom_range(0, 99) < 85) ? $urandom_range(32, 126) : $urandom_range(128, 255);
        default: b = ($urandom_range(0, 99) < 85) ? 10 : $urandom_range(0, 255);
      endcase
      if ($urandom_range(0, 99) < 8) gap = $urandom_range(TMO - 3, TMO + 3);
      else gap = $urandom_range(1, 4);
      send_byte(b, $urandom_range(1, 3), gap);
    end
    step(TMO + 10);

`ifdef CMD_CLEAR_EN
    do_reset();
    step(1);
    busy_cnt = 0;
    send_byte(8'hFF, 1, 1);
    step(40);
    send_byte(8'h41, 2, 1);
    step(N_COL * N_ROW);
    chk("busy_len", busy_cnt, N_COL * N_ROW);
    send_frame(8'h01, 8'h02, 8'h33, 8'h0A);
    step(TMO + 10);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
